// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Holds the NOP encoding, default reset PC and fetch state encodings.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSN     = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_1000;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] PC_ALIGN     = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    // Clear the byte-offset bits of an instruction address.
    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return a & PC_ALIGN;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read at a time,
// holds the fetched word for decode, discards responses made stale by redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] ir,
    output logic [31:0] pc_out,
    output logic        ir_valid
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_ir;
    logic [31:0] w_ir_nxt;
    logic [31:0] r_pc_out;
    logic [31:0] w_pc_out_nxt;
    logic        r_ir_valid;
    logic        w_ir_valid_nxt;

    logic        w_hs;
    logic        w_owed;
    logic [31:0] w_redir_pc;

    assign imem_req_valid = (r_state == ST_REQ);
    assign imem_req_addr  = r_pc;
    assign ir             = r_ir;
    assign pc_out         = r_pc_out;
    assign ir_valid       = r_ir_valid;

    assign w_hs       = imem_req_valid & imem_req_ready;
    assign w_redir_pc = align_pc(redirect_pc);

    // A response is still owed if a request is in flight after this cycle.
    assign w_owed = ((r_state == ST_WAIT) & ~imem_rsp_valid) |
                    ((r_state == ST_REQ)  & w_hs)            |
                    ((r_state == ST_DROP) & ~imem_rsp_valid);

    // Next-state and datapath update; redirect overrides every state.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_ir_nxt       = r_ir;
        w_pc_out_nxt   = r_pc_out;
        w_ir_valid_nxt = r_ir_valid;
        if (redirect_valid) begin
            w_pc_nxt       = w_redir_pc;
            w_ir_valid_nxt = 1'b0;
            w_state_nxt    = w_owed ? ST_DROP : ST_REQ;
        end else begin
            unique case (r_state)
                ST_REQ: begin
                    if (w_hs) begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        w_ir_nxt       = imem_rsp_data;
                        w_pc_out_nxt   = r_pc;
                        w_pc_nxt       = r_pc + PC_STEP;
                        w_ir_valid_nxt = 1'b1;
                        w_state_nxt    = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        w_ir_valid_nxt = 1'b0;
                        w_state_nxt    = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_rsp_valid) begin
                        w_state_nxt = ST_REQ;
                    end
                end
                default: begin
                    w_state_nxt = ST_REQ;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_REQ;
            r_pc       <= RESET_PC;
            r_ir       <= NOP_INSN;
            r_pc_out   <= 32'h0;
            r_ir_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_ir       <= w_ir_nxt;
            r_pc_out   <= w_pc_out_nxt;
            r_ir_valid <= w_ir_valid_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic,
// with the delivered instruction stream checked against a PC-sequence model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic [31:0] ir;
    logic [31:0] pc_out;
    logic        ir_valid;

    fetch_unit #(.RESET_PC(32'h0000_1000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .ir             (ir),
        .pc_out         (pc_out),
        .ir_valid       (ir_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_pc = 32'h0000_1000;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_cons = 0;

    logic        out_pend = 1'b0;
    logic [31:0] out_addr = 32'h0;
    int          lat = 0;
    logic        prv_stuck = 1'b0;
    logic [31:0] prv_addr = 32'h0;

    event mon_ev;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'h0010_0093;
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // One clock cycle: drive inputs away from the edge, then advance.
    task automatic drive(input logic rdy, input logic rsp, input logic rd,
                         input logic [31:0] rpc, input logic stl);
        logic hs;
        if (rst_n && prv_stuck) begin
            chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
            chk("req_hold_addr", imem_req_addr, prv_addr);
        end
        imem_req_ready = rdy;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem(out_addr) : 32'h0;
        redirect_valid = rd;
        redirect_pc    = rpc;
        stall          = stl;
        -> mon_ev;
        hs        = rst_n && imem_req_valid && rdy;
        prv_stuck = rst_n && imem_req_valid && !rdy && !rd;
        prv_addr  = imem_req_addr;
        if (rsp) out_pend = 1'b0;
        else if (out_pend && lat > 1) lat--;
        if (hs) begin
            out_pend = 1'b1;
            out_addr = imem_req_addr;
            lat      = $urandom_range(1, 3);
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each consumed instruction must be the next one in the
    // architectural PC sequence; a redirect restarts the sequence.
    initial begin : monitor
        exp_t e;
        forever begin
            @(mon_ev);
            if (rst_n) begin
                if (ir_valid && !stall) begin
                    n_cons++;
                    if (exp_q.size() == 0) begin
                        exp_q.push_back({model_pc, mem(model_pc)});
                        model_pc = model_pc + 32'd4;
                    end
                    e = exp_q.pop_front();
                    chk("sb_pc", pc_out, e.pc);
                    chk("sb_ir", ir, e.ir);
                end
                if (redirect_valid) begin
                    exp_q.delete();
                    model_pc = redirect_pc & 32'hFFFF_FFFC;
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] h_ir;
        logic [31:0] h_pc;
        logic [31:0] r32;
        logic        rdy;
        logic        rsp;
        logic        rd;
        logic        stl;
        logic [31:0] rpc;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_ir", ir, 32'h0000_0013);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        #10 rst_n = 1'b1;
        #1;
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0000_1000);

        drive(1, 0, 0, 0, 0);
        chk("wait_ir_valid", 32'(ir_valid), 32'd0);
        chk("wait_req_valid", 32'(imem_req_valid), 32'd0);
        drive(0, 1, 0, 0, 0);
        chk("lat_ir_valid", 32'(ir_valid), 32'd1);
        chk("lat_ir", ir, 32'h0010_0093);
        chk("lat_pc_out", pc_out, 32'h0000_1000);

        h_ir = ir;
        h_pc = pc_out;
        repeat (5) begin
            drive(0, 0, 0, 0, 1);
            chk("stall_ir", ir, h_ir);
            chk("stall_pc_out", pc_out, h_pc);
            chk("stall_ir_valid", 32'(ir_valid), 32'd1);
            chk("stall_no_req", 32'(imem_req_valid), 32'd0);
        end
        drive(0, 0, 0, 0, 0);
        chk("rel_ir_valid", 32'(ir_valid), 32'd0);
        chk("rel_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rel_req_addr", imem_req_addr, 32'h0000_1004);

        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 32'h0000_2002, 0);
        chk("drop_ir_valid", 32'(ir_valid), 32'd0);
        chk("drop_no_req", 32'(imem_req_valid), 32'd0);
        repeat (2) begin
            drive(0, 0, 0, 0, 0);
            chk("drop_wait_ir_valid", 32'(ir_valid), 32'd0);
        end
        drive(0, 1, 0, 0, 0);
        chk("stale_ir_valid", 32'(ir_valid), 32'd0);
        chk("stale_req_valid", 32'(imem_req_valid), 32'd1);
        chk("stale_req_addr", imem_req_addr, 32'h0000_2000);

        drive(1, 0, 0, 0, 0);
        drive(0, 1, 1, 32'h0000_3000, 0);
        chk("same_ir_valid", 32'(ir_valid), 32'd0);
        chk("same_req_valid", 32'(imem_req_valid), 32'd1);
        chk("same_req_addr", imem_req_addr, 32'h0000_3000);
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        chk("tgt_ir", ir, mem(32'h0000_3000));
        chk("tgt_pc_out", pc_out, 32'h0000_3000);

        drive(0, 0, 1, 32'hFFFF_FFFD, 1);
        chk("wrap_ir_valid", 32'(ir_valid), 32'd0);
        chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        chk("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
        chk("wrap_ir", ir, mem(32'hFFFF_FFFC));
        chk("wrap_valid", 32'(ir_valid), 32'd1);
        drive(0, 0, 0, 0, 0);
        chk("wrap_next_valid", 32'(imem_req_valid), 32'd1);
        chk("wrap_next_addr", imem_req_addr, 32'h0000_0000);

        drive(1, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ir", ir, 32'h0000_0013);
        chk("arst_pc_out", pc_out, 32'h0);
        chk("arst_ir_valid", 32'(ir_valid), 32'd0);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        out_pend       = 1'b0;
        prv_stuck      = 1'b0;
        exp_q.delete();
        model_pc = 32'h0000_1000;
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, 1, 0, 0, 0);
        chk("late_ir_valid", 32'(ir_valid), 32'd0);
        chk("late_req_valid", 32'(imem_req_valid), 32'd1);
        chk("late_req_addr", imem_req_addr, 32'h0000_1000);

        n_cons = 0;
        repeat (3000) begin
            r32 = $urandom;
            rdy = ($urandom_range(0, 3) != 0);
            rsp = out_pend && (lat == 1);
            rd  = ($urandom_range(0, 19) == 0);
            stl = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0)
                rpc = 32'hFFFF_FFF0 | (r32 & 32'h0000_000F);
            else
                rpc = r32 & 32'h0000_FFFF;
            drive(rdy, rsp, rd, rpc, stl);
        end
        chk("rand_progress", 32'(n_cons >= 50), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
